// File: rtl/alu_reg_sequencer_pkg.sv
// Shared definitions for the ALU operand/result sequencer: op codes,
// sequencer states and the default datapath width.
package alu_reg_sequencer_pkg;

   localparam int DEFAULT_WIDTH = 4;

   // Command op codes as they appear on cmd_op
   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_e;

   // Sequencer states: accept a command, compute for one cycle, hold the result
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      HOLD = 2'b10
   } seq_state_e;

endpackage

// File: rtl/alu_reg_sequencer_if.sv
// Command and result handshake bundle between a command producer/result
// consumer (master) and the sequencer (slave).
interface alu_reg_sequencer_if
   import alu_reg_sequencer_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic             cmd_acc;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_q;
   logic             res_carry;
   logic             res_zero;

   modport master (
      output cmd_valid, cmd_op, cmd_acc, cmd_a, cmd_b, res_ready,
      input  cmd_ready, res_valid, res_q, res_carry, res_zero
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_acc, cmd_a, cmd_b, res_ready,
      output cmd_ready, res_valid, res_q, res_carry, res_zero
   );

endinterface

// File: rtl/alu_reg_sequencer_alu_core_w.sv
// Purely combinational WIDTH-bit ALU. SUB is formed as A + ~B + 1 so the
// carry out of the top bit reads as "no borrow" (A >= B unsigned).
module alu_core_w
   import alu_reg_sequencer_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
   (
      input  logic [WIDTH-1:0] a,
      input  logic [WIDTH-1:0] b,
      input  alu_op_e          op,
      output logic [WIDTH-1:0] y,
      output logic             carry
   );

   logic [WIDTH:0] ext_sum;

   // Select the operation; logic ops never produce a carry
   always_comb begin
      ext_sum = '0;
      y       = '0;
      carry   = 1'b0;
      case (op)
         OP_ADD: begin
            ext_sum = {1'b0, a} + {1'b0, b};
            y       = ext_sum[WIDTH-1:0];
            carry   = ext_sum[WIDTH];
         end
         OP_SUB: begin
            ext_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            y       = ext_sum[WIDTH-1:0];
            carry   = ext_sum[WIDTH];
         end
         OP_AND: y = a & b;
         OP_OR:  y = a | b;
         default: begin
            y     = '0;
            carry = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_reg_sequencer.sv
// Command-driven operand/result sequencer. A command is latched in IDLE,
// evaluated from the latched operands in EXEC, and the registered result is
// held in HOLD until the consumer takes it. The accumulator tracks the last
// delivered result and can stand in for operand A.
module alu_reg_sequencer
   import alu_reg_sequencer_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH)
   (
      input  logic              clk,
      input  logic              rst,
      alu_reg_sequencer_if.slave bus,
      output logic              busy
   );

   seq_state_e       state;
   seq_state_e       next_state;
   logic             accept;
   logic             take;
   logic             load_result;

   alu_op_e          op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             zero_q;
   logic [WIDTH-1:0] acc_q;

   logic [WIDTH-1:0] alu_y;
   logic             alu_carry;

   // The ALU only ever sees the latched operands, never the live command bus
   alu_core_w #(.WIDTH(WIDTH)) u_alu (
      .a     (a_q),
      .b     (b_q),
      .op    (op_q),
      .y     (alu_y),
      .carry (alu_carry)
   );

   // State register; reset discards any in-flight command or held result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake decode: accept in IDLE, one EXEC cycle, wait in HOLD
   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      take        = 1'b0;
      load_result = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               accept     = 1'b1;
               next_state = EXEC;
            end
         end
         EXEC: begin
            load_result = 1'b1;
            next_state  = HOLD;
         end
         HOLD: begin
            if (bus.res_ready) begin
               take       = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand capture on accept; operand A comes from the accumulator in accumulate mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= OP_ADD;
         a_q  <= '0;
         b_q  <= '0;
      end else if (accept) begin
         op_q <= alu_op_e'(bus.cmd_op);
         a_q  <= bus.cmd_acc ? acc_q : bus.cmd_a;
         b_q  <= bus.cmd_b;
      end
   end

   // Result and flag registers, loaded once at the end of EXEC and frozen through HOLD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else if (load_result) begin
         result_q <= alu_y;
         carry_q  <= alu_carry;
         zero_q   <= (alu_y == '0);
      end
   end

   // Accumulator follows only delivered results, so a dropped result never feeds cmd_acc
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else if (take) begin
         acc_q <= result_q;
      end
   end

   assign bus.cmd_ready = (state == IDLE);
   assign bus.res_valid = (state == HOLD);
   assign bus.res_q     = result_q;
   assign bus.res_carry = carry_q;
   assign bus.res_zero  = zero_q;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Self-checking bench for alu_reg_sequencer: directed scenarios plus
// randomized commands against an arithmetic reference model.
module tb_alu_reg_sequencer;
   import alu_reg_sequencer_pkg::*;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   int vectors     = 0;
   int miscompares = 0;
   int model_acc   = 0;
   int exp_q;
   int exp_c;
   int exp_z;

   alu_reg_sequencer_if #(.WIDTH(W)) bus ();

   alu_reg_sequencer #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .busy (busy)
   );

   always #5 clk = ~clk;

   // Reference: unsigned arithmetic on integers, reduced modulo 2^W
   task automatic model(input int op, input int acc, input int a, input int b);
      int av;
      av = acc ? model_acc : a;
      case (op)
         0: begin exp_q = (av + b) % MOD; exp_c = ((av + b) >= MOD) ? 1 : 0; end
         1: begin exp_q = (av - b + MOD) % MOD; exp_c = (av >= b) ? 1 : 0; end
         2: begin exp_q = av & b; exp_c = 0; end
         default: begin exp_q = av | b; exp_c = 0; end
      endcase
      exp_z = (exp_q == 0) ? 1 : 0;
   endtask

   // Present a command at a falling edge, let the next rising edge accept it
   task automatic issue(input int op, input int acc, input int a, input int b);
      model(op, acc, a, b);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'(op);
      bus.cmd_acc   = acc[0];
      bus.cmd_a     = W'(a);
      bus.cmd_b     = W'(b);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   // Count falling edges until res_valid, bounded
   task automatic wait_res(output int edges);
      edges = 0;
      while (bus.res_valid !== 1'b1 && edges < 8) begin
         @(negedge clk);
         edges++;
      end
   endtask

   // Deliver the held result to the consumer
   task automatic take_result();
      bus.res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.res_ready = 1'b0;
      model_acc = exp_q;
   endtask

   task automatic test_reset();
      int e;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      vectors++;
      if ({bus.cmd_ready, bus.res_valid, bus.res_q, bus.res_carry, bus.res_zero, busy} !== 9'b1_0_0000_0_0_0) begin
         miscompares++;
         $display("FAIL reset_initial: got %b expected 100000000", {bus.cmd_ready, bus.res_valid, bus.res_q, bus.res_carry, bus.res_zero, busy});
      end
      @(negedge clk);
      rst = 1'b0;
      model_acc = 0;
      issue(0, 0, 9, 8);
      wait_res(e);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({bus.cmd_ready, bus.res_valid, bus.res_q, bus.res_carry, bus.res_zero, busy} !== 9'b1_0_0000_0_0_0) begin
         miscompares++;
         $display("FAIL reset_async: got %b expected 100000000", {bus.cmd_ready, bus.res_valid, bus.res_q, bus.res_carry, bus.res_zero, busy});
      end
      @(negedge clk);
      rst = 1'b0;
      model_acc = 0;
   endtask

   task automatic test_add();
      int e;
      issue(0, 0, 9, 8);
      vectors++;
      if ({bus.res_valid, busy, bus.cmd_ready} !== 3'b010) begin
         miscompares++;
         $display("FAIL add_exec_state: got %b expected 010", {bus.res_valid, busy, bus.cmd_ready});
      end
      wait_res(e);
      vectors++;
      if (e !== 1) begin
         miscompares++;
         $display("FAIL add_latency: got %0d expected 1", e);
      end
      vectors++;
      if ({bus.res_carry, bus.res_zero, bus.res_q} !== 6'b10_0001) begin
         miscompares++;
         $display("FAIL add_result: got %b expected 100001", {bus.res_carry, bus.res_zero, bus.res_q});
      end
      take_result();
      vectors++;
      if ({bus.cmd_ready, bus.res_valid, busy} !== 3'b100) begin
         miscompares++;
         $display("FAIL add_release: got %b expected 100", {bus.cmd_ready, bus.res_valid, busy});
      end
   endtask

   task automatic test_sub();
      int e;
      issue(1, 0, 3, 5);
      wait_res(e);
      vectors++;
      if ({bus.res_carry, bus.res_zero, bus.res_q} !== 6'b00_1110) begin
         miscompares++;
         $display("FAIL sub_borrow: got %b expected 001110", {bus.res_carry, bus.res_zero, bus.res_q});
      end
      take_result();
      issue(1, 0, 5, 5);
      wait_res(e);
      vectors++;
      if ({bus.res_carry, bus.res_zero, bus.res_q} !== 6'b11_0000) begin
         miscompares++;
         $display("FAIL sub_zero: got %b expected 110000", {bus.res_carry, bus.res_zero, bus.res_q});
      end
      take_result();
   endtask

   task automatic test_logic_acc();
      int e;
      issue(2, 0, 12, 10);
      wait_res(e);
      vectors++;
      if ({bus.res_carry, bus.res_q} !== 5'b0_1000) begin
         miscompares++;
         $display("FAIL and_result: got %b expected 01000", {bus.res_carry, bus.res_q});
      end
      take_result();
      issue(3, 1, 15, 1);
      wait_res(e);
      vectors++;
      if ({bus.res_carry, bus.res_q} !== 5'b0_1001) begin
         miscompares++;
         $display("FAIL or_acc_result: got %b expected 01001", {bus.res_carry, bus.res_q});
      end
      take_result();
   endtask

   task automatic test_backpressure();
      int e;
      issue(0, 0, 2, 3);
      wait_res(e);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_acc   = 1'b0;
      bus.cmd_a     = 4'd7;
      bus.cmd_b     = 4'd7;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if ({bus.res_valid, bus.cmd_ready, bus.res_q} !== 6'b10_0101) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got %b expected 100101", i, {bus.res_valid, bus.cmd_ready, bus.res_q});
         end
      end
      take_result();
      vectors++;
      if ({bus.cmd_ready, bus.res_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL stall_release: got %b expected 10", {bus.cmd_ready, bus.res_valid});
      end
      model(0, 0, 7, 7);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      vectors++;
      if ({busy, bus.res_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL stall_next_accept: got %b expected 10", {busy, bus.res_valid});
      end
      @(negedge clk);
      vectors++;
      if ({bus.res_valid, bus.res_carry, bus.res_q} !== 6'b10_1110) begin
         miscompares++;
         $display("FAIL stall_next_result: got %b expected 101110", {bus.res_valid, bus.res_carry, bus.res_q});
      end
      take_result();
   endtask

   task automatic test_reset_in_hold();
      int e;
      issue(0, 0, 4, 4);
      wait_res(e);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({bus.cmd_ready, bus.res_valid, bus.res_q, busy} !== 7'b10_0000_0) begin
         miscompares++;
         $display("FAIL hold_reset: got %b expected 1000000", {bus.cmd_ready, bus.res_valid, bus.res_q, busy});
      end
      @(negedge clk);
      rst = 1'b0;
      model_acc = 0;
      issue(0, 1, 15, 3);
      wait_res(e);
      vectors++;
      if ({bus.res_valid, bus.res_carry, bus.res_q} !== 6'b10_0011) begin
         miscompares++;
         $display("FAIL hold_reset_acc: got %b expected 100011", {bus.res_valid, bus.res_carry, bus.res_q});
      end
      take_result();
   endtask

   task automatic test_back_to_back();
      int op, acc, a, b;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         op  = int'($urandom_range(0, 3));
         acc = int'($urandom_range(0, 1));
         a   = int'($urandom_range(0, MOD - 1));
         b   = int'($urandom_range(0, MOD - 1));
         model(op, acc, a, b);
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = 2'(op);
         bus.cmd_acc   = acc[0];
         bus.cmd_a     = W'(a);
         bus.cmd_b     = W'(b);
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if ({busy, bus.cmd_ready, bus.res_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_exec[%0d]: got %b expected 100", i, {busy, bus.cmd_ready, bus.res_valid});
         end
         bus.cmd_op = 2'($urandom_range(0, 3));
         bus.cmd_a  = W'($urandom_range(0, MOD - 1));
         bus.cmd_b  = W'($urandom_range(0, MOD - 1));
         @(negedge clk);
         vectors++;
         if ({bus.res_valid, bus.res_carry, bus.res_zero, bus.res_q} !== {1'b1, exp_c[0], exp_z[0], exp_q[W-1:0]}) begin
            miscompares++;
            $display("FAIL b2b_result[%0d]: got %b expected %b", i, {bus.res_valid, bus.res_carry, bus.res_zero, bus.res_q}, {1'b1, exp_c[0], exp_z[0], exp_q[W-1:0]});
         end
         @(negedge clk);
         model_acc = exp_q;
         vectors++;
         if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready[%0d]: got %b expected 1", i, bus.cmd_ready);
         end
      end
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b0;
   endtask

   task automatic test_random();
      int op, acc, a, b, e, stalls;
      for (int i = 0; i < 25; i++) begin
         op  = int'($urandom_range(0, 3));
         acc = int'($urandom_range(0, 1));
         a   = int'($urandom_range(0, MOD - 1));
         b   = int'($urandom_range(0, MOD - 1));
         issue(op, acc, a, b);
         wait_res(e);
         vectors++;
         if (e !== 1) begin
            miscompares++;
            $display("FAIL rand_latency[%0d]: got %0d expected 1", i, e);
         end
         stalls = int'($urandom_range(0, 3));
         for (int s = 0; s <= stalls; s++) begin
            vectors++;
            if ({bus.res_valid, bus.res_carry, bus.res_zero, bus.res_q} !== {1'b1, exp_c[0], exp_z[0], exp_q[W-1:0]}) begin
               miscompares++;
               $display("FAIL rand_result[%0d.%0d]: op=%0d acc=%0d a=%0d b=%0d got %b expected %b", i, s, op, acc, a, b, {bus.res_valid, bus.res_carry, bus.res_zero, bus.res_q}, {1'b1, exp_c[0], exp_z[0], exp_q[W-1:0]});
            end
            if (s < stalls) @(negedge clk);
         end
         take_result();
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_acc   = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.res_ready = 1'b0;
      $display("[TB] starting alu_reg_sequencer bench");
      test_reset();
      test_add();
      test_sub();
      test_logic_acc();
      test_backpressure();
      test_reset_in_hold();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so a stuck handshake cannot hang the run
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
